// File: rtl/cipher_uart_tx_if.sv
// Valid/ready byte handshake between the cipher stage and the UART transmitter.
interface cipher_uart_tx_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/cipher_uart_tx.sv
// Buffers cipher bytes in a small FIFO and serialises them as 8N1-style UART frames
// (start bit, N data bits LSB-first, stop bit, no parity) on a single registered line.
module cipher_uart_tx #(
  parameter int N            = 8,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  cipher_uart_tx_if.slave                in_if,
  output logic                           tx,
  output logic                           busy,
  output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
  output logic                           overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int KW = $clog2(DEPTH + 1);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [KW-1:0] DEPTH_K  = KW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [BW-1:0] bit_r, bit_s;
  logic [N-1:0]  shift_r, shift_s;
  logic          tx_r, tx_s;
  logic          busy_r;
  logic          pop_s;
  logic          push_s;
  logic          ready_s;
  logic          has_data_s;
  logic          cnt_last_s;
  logic [KW-1:0] count_r;
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic          overflow_r;
  logic [N-1:0]  mem_r [DEPTH];

  // A full FIFO refuses pushes even on an edge where the serializer pops.
  assign ready_s        = (count_r < DEPTH_K);
  assign push_s         = in_if.in_valid && ready_s;
  assign has_data_s     = (count_r != {KW{1'b0}});
  assign cnt_last_s     = (cnt_r == CNT_LAST);
  assign in_if.in_ready = ready_s;
  assign tx             = tx_r;
  assign busy           = busy_r;
  assign fifo_count     = count_r;
  assign overflow       = overflow_r;

  // Serializer next-state, counters, shift register and next line level.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    tx_s    = tx_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (has_data_s) begin
          pop_s   = 1'b1;
          shift_s = mem_r[rd_ptr_r];
          state_s = START;
          cnt_s   = {CW{1'b0}};
          tx_s    = 1'b0;
        end else begin
          tx_s    = 1'b1;
        end
      end
      START: begin
        if (cnt_last_s) begin
          state_s = DATA;
          cnt_s   = {CW{1'b0}};
          bit_s   = {BW{1'b0}};
          tx_s    = shift_r[0];
        end else begin
          cnt_s   = cnt_r + CW'(1'b1);
        end
      end
      DATA: begin
        if (cnt_last_s) begin
          cnt_s = {CW{1'b0}};
          if (bit_r == BIT_LAST) begin
            state_s = STOP;
            tx_s    = 1'b1;
          end else begin
            shift_s = {1'b0, shift_r[N-1:1]};
            bit_s   = bit_r + BW'(1'b1);
            tx_s    = shift_r[1];
          end
        end else begin
          cnt_s = cnt_r + CW'(1'b1);
        end
      end
      STOP: begin
        if (cnt_last_s) begin
          cnt_s = {CW{1'b0}};
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (has_data_s) begin
            pop_s   = 1'b1;
            shift_s = mem_r[rd_ptr_r];
            state_s = START;
            tx_s    = 1'b0;
          end else begin
            state_s = IDLE;
            tx_s    = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CW'(1'b1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
        bit_s   = {BW{1'b0}};
        tx_s    = 1'b1;
      end
    endcase
  end

  // Serializer state register and registered line/busy outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      bit_r   <= {BW{1'b0}};
      shift_r <= {N{1'b0}};
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {KW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + KW'(1'b1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - KW'(1'b1);
      end else begin
        count_r <= count_r;
      end
      if (in_if.in_valid && !ready_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_if.in_data;
    end
  end

endmodule

// File: tb/tb_cipher_uart_tx.sv
// Randomised scoreboard bench: a frame-schedule model predicts acceptance and pop edges,
// a tx-line monitor decodes frames and compares them against the expected queue.
module tb_cipher_uart_tx;
  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = (N + 2) * CPB;
  localparam int KW    = $clog2(DEPTH + 1);

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          tx, busy, overflow;
  logic [KW-1:0] fifo_count;

  cipher_uart_tx_if #(.N(N)) bus ();

  cipher_uart_tx #(.N(N), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_if      (bus.slave),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    logic [N-1:0] d;
    int           pop;
  } exp_t;

  exp_t exp_q[$];
  int   pending[$];
  int   starts_q[$];
  int   last_pop = -1000;
  bit   ov_model = 1'b0;
  int   n_pass   = 0;
  int   n_total  = 0;

  task automatic check_eq(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  // Bytes still in the FIFO just before edge e: accepted earlier, popped at or after e.
  function automatic int occupancy(input int e);
    while (pending.size() > 0 && pending[0] < e) void'(pending.pop_front());
    return pending.size();
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pending.delete();
    last_pop = -1000;
    ov_model = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N-1:0] d);
    int  e, occ, p;
    bit  acc;
    e   = edge_n + 1;
    occ = occupancy(e);
    acc = (occ < DEPTH);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    check_eq("fifo_count", fifo_count, occ);
    check_eq("in_ready", bus.in_ready, acc);
    if (acc) begin
      p = (e + 1 > last_pop + FRAME) ? e + 1 : last_pop + FRAME;
      last_pop = p;
      pending.push_back(p);
      exp_q.push_back('{d: d, pop: p});
    end else begin
      ov_model = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq("overflow", overflow, ov_model);
  endtask

  task automatic drain(input int budget);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      @(posedge clk);
      #1;
      b++;
    end
    check_eq("drain", exp_q.size(), 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_tx", tx, 1);
  endtask

  task automatic check_defaults(input string tag);
    check_eq({tag, "_tx"}, tx, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_count"}, fifo_count, 0);
    check_eq({tag, "_ready"}, bus.in_ready, 1);
    check_eq({tag, "_ovf"}, overflow, 0);
  endtask

  // Monitor: decodes every frame on tx and scores it against the expected queue.
  initial begin : monitor
    bit           on;
    bit           ok;
    int           idx, bp, ph, st;
    logic [N-1:0] got;
    logic         lv0;
    exp_t         e;
    on = 1'b0; ok = 1'b1; idx = 0; st = 0; got = '0; lv0 = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        on = 1'b0;
      end else begin
        if (!on && tx === 1'b0) begin
          on = 1'b1; idx = 0; ok = 1'b1; got = '0; st = edge_n;
          starts_q.push_back(st);
        end
        if (on) begin
          bp = idx / CPB;
          ph = idx % CPB;
          if (ph == 0) lv0 = tx;
          else if (tx !== lv0) ok = 1'b0;
          if (bp == 0 && tx !== 1'b0) ok = 1'b0;
          if (bp == N + 1 && tx !== 1'b1) ok = 1'b0;
          if (bp >= 1 && bp <= N && ph == 0) got[bp-1] = tx;
          if (busy !== 1'b1) ok = 1'b0;
          idx++;
          if (idx == FRAME) begin
            on = 1'b0;
            if (exp_q.size() == 0) begin
              check_eq("frame_expected", exp_q.size(), 1);
            end else begin
              e = exp_q.pop_front();
              check_eq("frame_shape", ok, 1);
              check_eq("frame_data", got, e.d);
              check_eq("frame_start", st, e.pop);
            end
          end
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int target, p, bad;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_defaults("rst_init");
    #2 reset = 1'b0;
    idle(2);

    // Single byte: latency, line levels and busy window.
    push(8'hA5);
    check_eq("lat_pre_tx", tx, 1);
    @(posedge clk); #1;
    check_eq("lat_start_tx", tx, 0);
    check_eq("lat_busy", busy, 1);
    repeat (39) @(posedge clk);
    #1;
    check_eq("busy_hold", busy, 1);
    @(posedge clk); #1;
    check_eq("busy_fall", busy, 0);
    check_eq("stop_tx", tx, 1);
    drain(100);

    // Back-to-back frames with no idle cycle between them.
    starts_q.delete();
    push(8'h3C);
    push(8'hC3);
    drain(200);
    check_eq("b2b_frames", starts_q.size(), 2);
    if (starts_q.size() == 2) check_eq("b2b_gap", starts_q[1] - starts_q[0], FRAME);

    // Fill to full, then one rejected push.
    for (int i = 1; i <= 5; i++) push(N'(i));
    check_eq("full_count", fifo_count, DEPTH);
    check_eq("full_ready", bus.in_ready, 0);
    push(8'h06);
    check_eq("ovf_set", overflow, 1);
    drain(400);

    // Push on the very edge that the STOP->START pop occurs.
    push(8'h5A);
    push(8'h96);
    target = last_pop;
    while (edge_n + 1 < target) begin
      @(posedge clk);
      #1;
    end
    push(8'h69);
    check_eq("simul_count", fifo_count, 1);
    drain(200);

    // Randomised traffic with random gaps; some pushes hit a full FIFO.
    for (int i = 0; i < 80; i++) begin
      int gap;
      gap = $urandom_range(0, 12);
      if (gap > 0) idle(gap);
      push(N'($urandom));
    end
    drain(1000);

    // Reset in the middle of data bit 3 with two bytes queued.
    push(8'hFF);
    push(8'h11);
    push(8'h22);
    p = exp_q[0].pop;
    check_eq("pre_rst_count", fifo_count, 2);
    while (edge_n < p + 17) begin
      @(posedge clk);
      #1;
    end
    #2 reset = 1'b1;
    #1;
    check_defaults("rst_mid");
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_eq("post_rst_quiet", bad, 0);
    check_eq("post_rst_count", fifo_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cipher_uart_tx.md
Name: cipher_uart_tx

Overview:
- Downstream consumer of the stream-cipher byte output.
- Accepts cipher bytes over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each byte as an asynchronous UART frame: 1 start bit, N data bits LSB-first, 1 stop bit, no parity.
- Converts the parallel cipher result into a single-wire link toward the board interface.

Parameters:
- N, 8, data width in bits; the frame carries N data bits.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CLKS_PER_BIT, 4, clk cycles per serial bit; at least 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a byte to enqueue.
- in_data  input  N  cipher byte (message_out of the cipher stage).
- in_ready  output  1  FIFO can accept a byte this cycle.
- tx  output  1  serial line, idle high, registered.
- busy  output  1  serializer FSM is not IDLE.
- fifo_count  output  clog2(DEPTH+1)  current FIFO occupancy.
- overflow  output  1  sticky flag: in_valid was asserted while in_ready=0.

Behaviour:
- Reset (async, active-high): all outputs are forced immediately.
  - tx=1, busy=0, fifo_count=0, overflow=0, in_ready=1.
  - FSM goes to IDLE; FIFO pointers and the bit/cycle counters clear.
- Reset mid-frame aborts the frame. tx returns high at once and buffered bytes are discarded.
- FIFO push:
  - A push happens on a rising edge when in_valid && in_ready.
  - in_ready = (fifo_count < DEPTH) and is combinational from the registered count.
  - When full, in_ready=0 even if a pop occurs in the same cycle; a full FIFO never accepts on a pop edge.
- Overflow: set on an edge where in_valid && !in_ready. It holds until reset.
- Pointers: read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- fifo_count update:
  - +1 on a push only.
  - -1 on a pop only.
  - Unchanged when a push and a pop occur on the same edge.
- FSM states: IDLE, START, DATA, STOP. A cycle counter runs 0..CLKS_PER_BIT-1, and a bit index runs 0..N-1.
- IDLE, fifo_count>0 on an edge:
  - Pop the head into the shift register.
  - Next state START, counter=0, and tx<=0 on that same edge.
- START: after CLKS_PER_BIT cycles, go to DATA with bit index 0 and tx<=shift[0].
- DATA:
  - Each bit is held CLKS_PER_BIT cycles, then the register shifts right and tx<=next bit.
  - After bit N-1 has been held, go to STOP with tx<=1.
- STOP: held CLKS_PER_BIT cycles, then:
  - If fifo_count>0: pop, go to START, tx<=0 (back-to-back frames with no idle gap).
  - Else: go to IDLE, tx stays 1.
- Frame length: exactly (N+2)*CLKS_PER_BIT cycles from the tx falling edge to the end of the stop bit.
- Latency: a byte accepted at edge k into an empty FIFO while IDLE is popped at edge k+1, so tx falls after edge k+1.
- A push to an empty FIFO on the same edge the FSM checks occupancy is not visible until the next edge.
- busy=1 from the START-entry edge until the edge that returns the FSM to IDLE.
- in_data is sampled only on push edges. Bytes enqueued while a frame is active wait in FIFO order.

Test Plan:
- Reset defaults: assert reset mid-simulation without a clock edge -> tx=1, busy=0, fifo_count=0, in_ready=1, overflow=0 immediately.
- Single byte, CLKS_PER_BIT=4, N=8: push 0xA5 at edge k.
  - tx=0 for 4 cycles starting after edge k+1.
  - Data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1 for 4 cycles.
  - busy falls after 40 cycles and tx stays 1.
- Back-to-back: push 0x3C, 0xC3 on consecutive edges -> two 40-cycle frames with no idle cycle between the stop of 0x3C and the start of 0xC3.
- Full/overflow, DEPTH=4: push 5 bytes 0x01..0x05 one per cycle while the serializer is busy.
  - 0x01 pops immediately, so 0x02..0x05 fill the FIFO: fifo_count=4, in_ready=0.
  - A sixth push attempt sets overflow=1 and its data is dropped.
  - All 5 accepted bytes appear on tx in order.
- Simultaneous push/pop: with fifo_count=1, push on the edge the STOP->START pop occurs -> fifo_count stays 1 and ordering is preserved.
- Reset mid-frame: assert reset during DATA bit 3 of 0xFF with 2 bytes queued.
  - tx=1 at once and fifo_count=0.
  - After reset release with no pushes, tx stays 1 and busy=0.
